mem_wb_stage: RTL and testbench



---
 rtl/mem_wb_stage.sv | 134 +++++++++++++
 tb/tb_mem_wb_stage.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/mem_wb_stage.sv
// MEM->WB pipeline register with a 2-entry skid buffer, synchronous flush and x0 write squash.
// Optional stall counter output enabled by defining MEM_WB_STALL_CNT_EN.
module mem_wb_stage #(
   parameter int DATA_W      = 32,
   parameter int ADDR_W      = 5,
   parameter bit ZERO_SQUASH = 1'b1,
   parameter int CNT_W       = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush_i,
   input  logic              up_valid_i,
   output logic              up_ready_o,
   input  logic [DATA_W-1:0] up_data_i,
   input  logic [ADDR_W-1:0] up_waddr_i,
   input  logic              up_we_i,
   output logic              dn_valid_o,
   input  logic              dn_ready_i,
   output logic [DATA_W-1:0] dn_data_o,
   output logic [ADDR_W-1:0] dn_waddr_o,
`ifdef MEM_WB_STALL_CNT_EN
   output logic [CNT_W-1:0]  stall_cnt_o,
`endif
   output logic              dn_we_o
);

   logic              main_valid_q, main_valid_d;
   logic [DATA_W-1:0] main_data_q,  main_data_d;
   logic [ADDR_W-1:0] main_waddr_q, main_waddr_d;
   logic              main_we_q,    main_we_d;
   logic              skid_valid_q, skid_valid_d;
   logic [DATA_W-1:0] skid_data_q,  skid_data_d;
   logic [ADDR_W-1:0] skid_waddr_q, skid_waddr_d;
   logic              skid_we_q,    skid_we_d;
   logic              up_ready_q,   up_ready_d;

   logic accept;
   logic drain;
   logic in_we;

   assign accept = up_valid_i & up_ready_q;
   assign drain  = main_valid_q & dn_ready_i;
   // Writes to x0 are architecturally void, so drop the enable at capture time.
   assign in_we  = up_we_i & (!ZERO_SQUASH || (up_waddr_i != '0));

   always_comb begin
      main_valid_d = main_valid_q;
      main_data_d  = main_data_q;
      main_waddr_d = main_waddr_q;
      main_we_d    = main_we_q;
      skid_valid_d = skid_valid_q;
      skid_data_d  = skid_data_q;
      skid_waddr_d = skid_waddr_q;
      skid_we_d    = skid_we_q;

      if (flush_i) begin
         main_valid_d = 1'b0;
         skid_valid_d = 1'b0;
      end else if (skid_valid_q) begin
         // Ready is low whenever skid is occupied, so no accept can coincide here.
         if (drain) begin
            main_data_d  = skid_data_q;
            main_waddr_d = skid_waddr_q;
            main_we_d    = skid_we_q;
            skid_valid_d = 1'b0;
         end
      end else if (main_valid_q && !drain) begin
         if (accept) begin
            skid_valid_d = 1'b1;
            skid_data_d  = up_data_i;
            skid_waddr_d = up_waddr_i;
            skid_we_d    = in_we;
         end
      end else begin
         main_valid_d = accept;
         if (accept) begin
            main_data_d  = up_data_i;
            main_waddr_d = up_waddr_i;
            main_we_d    = in_we;
         end
      end

      up_ready_d = !skid_valid_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         main_valid_q <= 1'b0;
         main_data_q  <= '0;
         main_waddr_q <= '0;
         main_we_q    <= 1'b0;
         skid_valid_q <= 1'b0;
         skid_data_q  <= '0;
         skid_waddr_q <= '0;
         skid_we_q    <= 1'b0;
         up_ready_q   <= 1'b1;
      end else begin
         main_valid_q <= main_valid_d;
         main_data_q  <= main_data_d;
         main_waddr_q <= main_waddr_d;
         main_we_q    <= main_we_d;
         skid_valid_q <= skid_valid_d;
         skid_data_q  <= skid_data_d;
         skid_waddr_q <= skid_waddr_d;
         skid_we_q    <= skid_we_d;
         up_ready_q   <= up_ready_d;
      end
   end

   assign up_ready_o = up_ready_q;
   assign dn_valid_o = main_valid_q;
   assign dn_data_o  = main_data_q;
   assign dn_waddr_o = main_waddr_q;
   assign dn_we_o    = main_we_q & main_valid_q;

`ifdef MEM_WB_STALL_CNT_EN
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

   // Saturating count of cycles WB refused a presented beat; survives flush.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (main_valid_q && !dn_ready_i && (stall_cnt_q != {CNT_W{1'b1}}))
         stall_cnt_d = stall_cnt_q + 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) stall_cnt_q <= '0;
      else        stall_cnt_q <= stall_cnt_d;
   end

   assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed table-driven bench for mem_wb_stage; also checks the stall counter when MEM_WB_STALL_CNT_EN is defined.
module tb_mem_wb_stage;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 5;
   localparam int CNT_W  = 4;
   localparam int NV     = 23;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              flush_i = 1'b0;
   logic              up_valid_i = 1'b0;
   logic              up_ready_o;
   logic [DATA_W-1:0] up_data_i = '0;
   logic [ADDR_W-1:0] up_waddr_i = '0;
   logic              up_we_i = 1'b0;
   logic              dn_valid_o;
   logic              dn_ready_i = 1'b0;
   logic [DATA_W-1:0] dn_data_o;
   logic [ADDR_W-1:0] dn_waddr_o;
   logic              dn_we_o;
`ifdef MEM_WB_STALL_CNT_EN
   logic [CNT_W-1:0]  stall_cnt_o;
`endif

   mem_wb_stage #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_SQUASH(1'b1), .CNT_W(CNT_W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .flush_i    (flush_i),
      .up_valid_i (up_valid_i),
      .up_ready_o (up_ready_o),
      .up_data_i  (up_data_i),
      .up_waddr_i (up_waddr_i),
      .up_we_i    (up_we_i),
      .dn_valid_o (dn_valid_o),
      .dn_ready_i (dn_ready_i),
      .dn_data_o  (dn_data_o),
      .dn_waddr_o (dn_waddr_o),
`ifdef MEM_WB_STALL_CNT_EN
      .stall_cnt_o(stall_cnt_o),
`endif
      .dn_we_o    (dn_we_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic              flush;
      logic              vld;
      logic [DATA_W-1:0] data;
      logic [ADDR_W-1:0] waddr;
      logic              we;
      logic              rdy;
      logic              e_ur;
      logic              e_dv;
      logic [DATA_W-1:0] e_data;
      logic [ADDR_W-1:0] e_waddr;
      logic              e_we;
   } vec_t;

   vec_t vecs [NV];
   int   n_vec  = 0;
   int   n_fail = 0;

   task automatic check(input string name, input logic ur, input logic dv,
                        input logic [DATA_W-1:0] d, input logic [ADDR_W-1:0] a, input logic we);
      n_vec++;
      if ({up_ready_o, dn_valid_o, dn_data_o, dn_waddr_o, dn_we_o} !== {ur, dv, d, a, we}) begin
         n_fail++;
         $display("FAIL %s: got ur=%b dv=%b data=%h waddr=%0d we=%b, want ur=%b dv=%b data=%h waddr=%0d we=%b",
                  name, up_ready_o, dn_valid_o, dn_data_o, dn_waddr_o, dn_we_o, ur, dv, d, a, we);
      end else begin
         $display("ok   %s: ur=%b dv=%b data=%h waddr=%0d we=%b", name, ur, dv, d, a, we);
      end
   endtask

   task automatic drive(input logic fl, input logic v, input logic [DATA_W-1:0] d,
                        input logic [ADDR_W-1:0] a, input logic we, input logic r);
      flush_i = fl; up_valid_i = v; up_data_i = d; up_waddr_i = a; up_we_i = we; dn_ready_i = r;
   endtask

   function automatic vec_t mk(input logic fl, input logic v, input logic [DATA_W-1:0] d,
                               input logic [ADDR_W-1:0] a, input logic we, input logic r,
                               input logic eur, input logic edv, input logic [DATA_W-1:0] ed,
                               input logic [ADDR_W-1:0] ea, input logic ewe);
      vec_t t;
      t.flush = fl; t.vld = v; t.data = d; t.waddr = a; t.we = we; t.rdy = r;
      t.e_ur = eur; t.e_dv = edv; t.e_data = ed; t.e_waddr = ea; t.e_we = ewe;
      return t;
   endfunction

   initial begin
      // Streaming: each beat visible the edge after it is accepted.
      for (int i = 0; i < 8; i++)
         vecs[i] = mk(0, 1, 32'h1000 + i, 5'(i + 1), 1, 1,  1, 1, 32'h1000 + i, 5'(i + 1), 1);
      vecs[8]  = mk(0, 0, 0, 0, 0, 1,                     1, 0, 32'h1007, 8, 0);
      // Back-pressure through the skid entry.
      vecs[9]  = mk(0, 1, 32'hA, 3, 1, 0,                 1, 1, 32'hA, 3, 1);
      vecs[10] = mk(0, 1, 32'hB, 4, 1, 0,                 0, 1, 32'hA, 3, 1);
      vecs[11] = mk(0, 1, 32'hC, 5, 1, 0,                 0, 1, 32'hA, 3, 1);
      vecs[12] = mk(0, 1, 32'hC, 5, 1, 1,                 1, 1, 32'hB, 4, 1);
      vecs[13] = mk(0, 1, 32'hC, 5, 1, 1,                 1, 1, 32'hC, 5, 1);
      vecs[14] = mk(0, 0, 0, 0, 0, 1,                     1, 0, 32'hC, 5, 0);
      // x0 squash and plain we=0.
      vecs[15] = mk(0, 1, 32'hDEADBEEF, 0, 1, 0,          1, 1, 32'hDEADBEEF, 0, 0);
      vecs[16] = mk(0, 0, 0, 0, 0, 1,                     1, 0, 32'hDEADBEEF, 0, 0);
      vecs[17] = mk(0, 1, 32'h55, 7, 0, 0,                1, 1, 32'h55, 7, 0);
      // Flush with both entries full, then flush discarding a same-cycle accept.
      vecs[18] = mk(0, 1, 32'h66, 8, 1, 0,                0, 1, 32'h55, 7, 0);
      vecs[19] = mk(1, 1, 32'h77, 9, 1, 0,                1, 0, 32'h55, 7, 0);
      vecs[20] = mk(0, 1, 32'h88, 10, 1, 0,               1, 1, 32'h88, 10, 1);
      vecs[21] = mk(1, 1, 32'h99, 11, 1, 0,               1, 0, 32'h88, 10, 0);
      vecs[22] = mk(0, 0, 0, 0, 0, 1,                     1, 0, 32'h88, 10, 0);

      #12;
      check("reset", 1, 0, 0, 0, 0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < NV; i++) begin
         drive(vecs[i].flush, vecs[i].vld, vecs[i].data, vecs[i].waddr, vecs[i].we, vecs[i].rdy);
         @(posedge clk); #1;
         check($sformatf("vec%0d", i), vecs[i].e_ur, vecs[i].e_dv, vecs[i].e_data,
               vecs[i].e_waddr, vecs[i].e_we);
      end

      // Async reset mid-cycle with both entries full.
      drive(0, 1, 32'h1234, 6, 1, 0);
      @(posedge clk); #1;
      drive(0, 1, 32'h5678, 9, 1, 0);
      @(posedge clk); #1;
      check("fill_both", 0, 1, 32'h1234, 6, 1);
      drive(0, 0, 0, 0, 0, 0);
      #2 rst_n = 1'b0;
      #1 check("async_reset", 1, 0, 0, 0, 0);
      @(negedge clk);
      rst_n = 1'b1;
      // Skid content must be gone: nothing appears afterwards.
      drive(0, 0, 0, 0, 0, 1);
      @(posedge clk); #1;
      check("post_reset_idle", 1, 0, 0, 0, 0);

`ifdef MEM_WB_STALL_CNT_EN
      drive(0, 1, 32'h42, 2, 1, 0);
      @(posedge clk); #1;
      drive(0, 0, 0, 0, 0, 0);
      repeat (20) @(posedge clk);
      #1;
      n_vec++;
      if (stall_cnt_o !== 4'd15) begin
         n_fail++;
         $display("FAIL stall_sat: got %0d, want 15", stall_cnt_o);
      end else $display("ok   stall_sat: 15");
      drive(1, 0, 0, 0, 0, 0);
      @(posedge clk); #1;
      drive(0, 0, 0, 0, 0, 0);
      n_vec++;
      if (stall_cnt_o !== 4'd15 || dn_valid_o !== 1'b0) begin
         n_fail++;
         $display("FAIL stall_flush: got cnt=%0d dv=%b, want cnt=15 dv=0", stall_cnt_o, dn_valid_o);
      end else $display("ok   stall_flush: 15");
      #2 rst_n = 1'b0;
      #1;
      n_vec++;
      if (stall_cnt_o !== 4'd0) begin
         n_fail++;
         $display("FAIL stall_reset: got %0d, want 0", stall_cnt_o);
      end else $display("ok   stall_reset: 0");
      @(negedge clk);
      rst_n = 1'b1;
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
